// File: rtl/bram_fifo_reader_pkg.sv
// bram_fifo_reader_pkg
//   Shared constants and helpers for the BRAM FIFO read-side controller.
//   READ_LATENCY : RAM read latency in cycles (registered read port)
//   QUEUE_DEPTH  : entries in the output skid queue
//   QCNT_W       : width of the queue occupancy count (0..QUEUE_DEPTH)
//   ptr_t        : pointer type for the default ABITS=9 configuration
//   occupancy()  : modular pointer difference; callers keep the low ABITS+1 bits
package bram_fifo_reader_pkg;

    localparam int READ_LATENCY  = 2;
    localparam int QUEUE_DEPTH   = 4;
    localparam int QCNT_W        = $clog2(QUEUE_DEPTH + 1);
    localparam int DEFAULT_ABITS = 9;

    typedef logic [DEFAULT_ABITS:0] ptr_t;

    // Pointers wrap mod 2**(ABITS+1); the low ABITS+1 bits of a 32-bit
    // difference equal the modular difference, so one helper covers all widths.
    function automatic logic [31:0] occupancy(input logic [31:0] a, input logic [31:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/bram_fifo_reader_queue.sv
// bram_fifo_reader_queue
//   4-entry register FIFO that absorbs words returning from the RAM.
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   push/push_data : write one word at the clock edge
//   pop            : drop the head entry at the clock edge (caller ensures count != 0)
//   head           : current head word (zero after reset)
//   count          : number of valid entries, 0..QUEUE_DEPTH
module bram_fifo_reader_queue
    import bram_fifo_reader_pkg::*;
#(
    parameter int DBITS = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DBITS-1:0]  push_data,
    input  logic              pop,
    output logic [DBITS-1:0]  head,
    output logic [QCNT_W-1:0] count
);

    localparam int IW = $clog2(QUEUE_DEPTH);

    logic [QUEUE_DEPTH-1:0][DBITS-1:0] mem;
    logic [IW-1:0]                     wr_idx;
    logic [IW-1:0]                     rd_idx;

    assign head = mem[rd_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx <= rd_idx + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The issuer's credit rule keeps a push away from a full queue.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && count == QCNT_W'(QUEUE_DEPTH)));

endmodule

// File: rtl/bram_fifo_reader.sv
// bram_fifo_reader
//   Read-side controller for a FIFO on a dual-port BRAM with 2-cycle read
//   latency. Issues reads while the writer's pointer is ahead, tracks reads in
//   flight, and buffers returned words so the consumer sees a full-rate stream.
//   clock, reset : sole clock (rising edge), asynchronous active-high reset
//   w_ptr        : writer pointer (MSB = wrap bit), one past the last written word
//   r_addr       : RAM read address, driven every cycle
//   r_data       : RAM read data, valid two cycles after r_addr
//   o_data/o_valid/o_ready : output stream, transfer on o_valid && o_ready
//   r_ptr        : consumed pointer returned to the writer for full detection
//   o_level      : (only with BRAM_FIFO_READER_LEVEL_EN) registered w_ptr - r_ptr
module bram_fifo_reader
    import bram_fifo_reader_pkg::*;
#(
    parameter int ABITS = 9,
    parameter int DBITS = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [ABITS:0]   w_ptr,
    output logic [ABITS-1:0] r_addr,
    input  logic [DBITS-1:0] r_data,
    output logic [DBITS-1:0] o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [ABITS:0]   r_ptr
`ifdef BRAM_FIFO_READER_LEVEL_EN
    ,
    output logic [ABITS:0]   o_level
`endif
);

    logic [ABITS:0]            issue_ptr;
    logic [READ_LATENCY-1:0]   vld_pipe;
    logic [QCNT_W-1:0]         inflight;
    logic [QCNT_W-1:0]         q_count;
    logic                      empty;
    logic                      issue;
    logic                      push;
    logic                      pop;

    // Reads in flight; together with the queue count this is the credit in use.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + QCNT_W'(vld_pipe[i]);
        end
    end

    // A same-cycle pop earns no credit: this keeps the path from o_ready off
    // the issue logic at the cost of nothing in steady state (3 of 4 credits).
    assign empty   = (w_ptr == issue_ptr);
    assign issue   = !empty &&
                     (({1'b0, q_count} + {1'b0, inflight}) < (QCNT_W + 1)'(QUEUE_DEPTH));
    assign push    = vld_pipe[READ_LATENCY-1];
    assign o_valid = (q_count != '0);
    assign pop     = o_valid && o_ready;
    assign r_addr  = issue_ptr[ABITS-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_ptr <= '0;
            r_ptr     <= '0;
            vld_pipe  <= '0;
        end else begin
            if (issue) begin
                issue_ptr <= issue_ptr + 1'b1;
            end
            if (pop) begin
                r_ptr <= r_ptr + 1'b1;
            end
            vld_pipe <= {vld_pipe[READ_LATENCY-2:0], issue};
        end
    end

    bram_fifo_reader_queue #(
        .DBITS (DBITS)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (r_data),
        .pop       (pop),
        .head      (o_data),
        .count     (q_count)
    );

`ifdef BRAM_FIFO_READER_LEVEL_EN
    logic [31:0] level_d;

    assign level_d = occupancy(32'(w_ptr), 32'(r_ptr));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_level <= '0;
        end else begin
            o_level <= level_d[ABITS:0];
        end
    end
`endif

endmodule

// File: tb/tb_bram_fifo_reader.sv
// tb_bram_fifo_reader
//   Directed bench for bram_fifo_reader. A main instance (ABITS=9) covers
//   reset, single word, streaming, backpressure and mid-stream reset; a small
//   instance (ABITS=4) with a full-respecting writer covers pointer wrap.
module tb_bram_fifo_reader;

    logic        clock;
    logic        reset;

    logic [9:0]  w_ptr;
    logic [8:0]  r_addr;
    logic [63:0] r_data;
    logic [63:0] o_data;
    logic        o_valid;
    logic        o_ready;
    logic [9:0]  r_ptr;

    logic [4:0]  w_ptr_w;
    logic [3:0]  r_addr_w;
    logic [63:0] r_data_w;
    logic [63:0] o_data_w;
    logic        o_valid_w;
    logic        o_ready_w;
    logic [4:0]  r_ptr_w;

`ifdef BRAM_FIFO_READER_LEVEL_EN
    logic [9:0]  o_level;
    logic [4:0]  o_level_w;
`endif

    int errors;
    int checks;

    bram_fifo_reader #(.ABITS(9), .DBITS(64)) dut (
        .clock   (clock),
        .reset   (reset),
        .w_ptr   (w_ptr),
        .r_addr  (r_addr),
        .r_data  (r_data),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .r_ptr   (r_ptr)
`ifdef BRAM_FIFO_READER_LEVEL_EN
        ,
        .o_level (o_level)
`endif
    );

    bram_fifo_reader #(.ABITS(4), .DBITS(64)) dut_w (
        .clock   (clock),
        .reset   (reset),
        .w_ptr   (w_ptr_w),
        .r_addr  (r_addr_w),
        .r_data  (r_data_w),
        .o_data  (o_data_w),
        .o_valid (o_valid_w),
        .o_ready (o_ready_w),
        .r_ptr   (r_ptr_w)
`ifdef BRAM_FIFO_READER_LEVEL_EN
        ,
        .o_level (o_level_w)
`endif
    );

    // RAM read-port models: address sampled at an edge, data two edges later.
    logic [63:0] ram   [512];
    logic [63:0] ram_w [16];
    logic [63:0] q1, q1_w;

    always @(posedge clock) begin
        q1     <= ram[r_addr];
        r_data <= q1;
        q1_w     <= ram_w[r_addr_w];
        r_data_w <= q1_w;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] wexp(input int i);
        return (i == 0) ? 64'h00000000_000000A5 : {32'hD000_0000, 32'(i)};
    endfunction

    function automatic logic [63:0] wdat(input int i);
        return {32'hBEEF_0000, 32'(i)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        w_ptr     = '0;
        w_ptr_w   = '0;
        o_ready   = 1'b0;
        o_ready_w = 1'b0;
        repeat (2) tick;
        reset = 1'b0;
    endtask

    // Consume n words from the main instance, checking order from index start.
    task automatic drain(input int n, input int start, input int budget, input bit toggle,
                         output int got, output int gaps, output int maxout);
        int   k;
        bit   started;
        bit   tg;
        logic [8:0] outst;
        k = 0; started = 0; tg = 0; gaps = 0; maxout = 0;
        for (int c = 0; c < budget && k < n; c++) begin
            o_ready = toggle ? tg : 1'b1;
            tg      = ~tg;
            outst   = r_addr - r_ptr[8:0];
            if (int'(outst) > maxout) maxout = int'(outst);
            if (o_valid && o_ready) begin
                chk($sformatf("data[%0d]", start + k), o_data, wexp(start + k));
                k++;
                started = 1;
            end else if (started) begin
                gaps++;
            end
            tick;
        end
        got     = k;
        o_ready = 1'b0;
    endtask

    initial begin
        int   got, gaps, maxout;
        int   written, consumed, maxocc;
        bit   full_seen, msb_seen, stale;
        logic [4:0] occ;

        errors = 0; checks = 0;
        reset = 1'b1; w_ptr = 10'd5; o_ready = 1'b0;
        w_ptr_w = '0; o_ready_w = 1'b0;
        for (int i = 0; i < 512; i++) ram[i] = wexp(i);
        for (int i = 0; i < 16; i++) ram_w[i] = '0;

        // Reset held with data pending at the writer
        repeat (3) tick;
        chk("rst_o_valid", 64'(o_valid), 64'(0));
        chk("rst_r_ptr",   64'(r_ptr),   64'(0));
        chk("rst_r_addr",  64'(r_addr),  64'(0));
        chk("rst_o_data",  o_data,       64'(0));
        reset = 1'b0;
        tick;
        chk("first_issue_addr", 64'(r_addr), 64'(1));
        drain(5, 0, 40, 1'b0, got, gaps, maxout);
        chk("rst_words_got", 64'(got), 64'(5));
        chk("rst_r_ptr_end", 64'(r_ptr), 64'(5));

        // Single word: latency 3 cycles from w_ptr change
        do_reset;
        o_ready = 1'b1;
        tick;
        w_ptr = 10'd1;
        chk("single_n0_valid", 64'(o_valid), 64'(0));
        tick;
        chk("single_n1_valid", 64'(o_valid), 64'(0));
        tick;
        chk("single_n2_valid", 64'(o_valid), 64'(0));
        tick;
        chk("single_n3_valid", 64'(o_valid), 64'(1));
        chk("single_n3_data",  o_data,       64'h A5);
        chk("single_n3_r_ptr", 64'(r_ptr),   64'(0));
        tick;
        chk("single_n4_r_ptr", 64'(r_ptr),   64'(1));
        chk("single_n4_valid", 64'(o_valid), 64'(0));
        chk("single_r_addr",   64'(r_addr),  64'(1));

        // Streaming at full rate
        do_reset;
        w_ptr = 10'd100;
        drain(100, 0, 300, 1'b0, got, gaps, maxout);
        chk("stream_got",    64'(got),    64'(100));
        chk("stream_gaps",   64'(gaps),   64'(0));
        chk("stream_maxout", 64'(maxout), 64'(3));
        chk("stream_r_ptr",  64'(r_ptr),  64'(100));
        chk("stream_empty",  64'(o_valid), 64'(0));

        // Backpressure: four credits, then resume one cycle after a pop
        do_reset;
        w_ptr = 10'd20;
        repeat (10) tick;
        chk("bp_stall_addr", 64'(r_addr), 64'(4));
        chk("bp_valid",      64'(o_valid), 64'(1));
        chk("bp_head",       o_data,       wexp(0));
        o_ready = 1'b1;
        tick;
        o_ready = 1'b0;
        chk("bp_pop_r_ptr",   64'(r_ptr),  64'(1));
        chk("bp_addr_hold",   64'(r_addr), 64'(4));
        tick;
        chk("bp_addr_resume", 64'(r_addr), 64'(5));
        drain(19, 1, 200, 1'b1, got, gaps, maxout);
        chk("bp_got",        64'(got),            64'(19));
        chk("bp_maxout_le4", 64'(maxout <= 4),    64'(1));
        chk("bp_r_ptr",      64'(r_ptr),          64'(20));

        // Wrap on the small instance, writer respecting full
        do_reset;
        written = 0; consumed = 0; maxocc = 0;
        full_seen = 0; msb_seen = 0;
        for (int c = 0; c < 2000 && consumed < 40; c++) begin
            occ = w_ptr_w - r_ptr_w;
            if (occ == 5'd16) full_seen = 1;
            if (written < 40 && occ != 5'd16) begin
                ram_w[w_ptr_w[3:0]] = wdat(written);
                w_ptr_w = w_ptr_w + 5'd1;
                written++;
            end
            occ = w_ptr_w - r_ptr_w;
            if (int'(occ) > maxocc) maxocc = int'(occ);
            o_ready_w = (c < 40) ? 1'b0 : (c % 3 != 0);
            if (r_ptr_w[4]) msb_seen = 1;
            if (o_valid_w && o_ready_w) begin
                chk($sformatf("wrap_data[%0d]", consumed), o_data_w, wdat(consumed));
                consumed++;
            end
            tick;
        end
        o_ready_w = 1'b0;
        chk("wrap_consumed",  64'(consumed),  64'(40));
        chk("wrap_r_ptr",     64'(r_ptr_w),   64'(8));
        chk("wrap_full_seen", 64'(full_seen), 64'(1));
        chk("wrap_max_occ",   64'(maxocc),    64'(16));
        chk("wrap_msb_seen",  64'(msb_seen),  64'(1));

        // Reset with reads in flight and words queued
        do_reset;
        w_ptr = 10'd20;
        repeat (4) tick;
        chk("mid_pre_valid", 64'(o_valid), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid",  64'(o_valid), 64'(0));
        chk("mid_rst_r_ptr",  64'(r_ptr),   64'(0));
        chk("mid_rst_r_addr", 64'(r_addr),  64'(0));
        chk("mid_rst_o_data", o_data,       64'(0));
        w_ptr = '0;
        repeat (2) tick;
        reset   = 1'b0;
        o_ready = 1'b1;
        stale   = 0;
        repeat (10) begin
            if (o_valid) stale = 1;
            tick;
        end
        chk("mid_no_stale", 64'(stale), 64'(0));
        w_ptr = 10'd1;
        repeat (3) tick;
        chk("mid_new_valid", 64'(o_valid), 64'(1));
        chk("mid_new_data",  o_data,       64'h A5);
        tick;
        chk("mid_new_r_ptr", 64'(r_ptr),   64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
